jtcomsc_snd_comm: RTL



---
 rtl/jtcomsc_snd_comm_pkg.sv | 9 +
 rtl/jtcomsc_cmd_fifo.sv | 66 ++++++
 rtl/jtcomsc_snd_comm.sv | 103 ++++++++++
 3 files changed

// File: rtl/jtcomsc_snd_comm_pkg.sv
// Shared types for the main-to-sound command channel.
//   cmd_t : one command byte as written by the main CPU
package jtcomsc_snd_comm_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef logic [BYTE_W-1:0] cmd_t;

endpackage

// File: rtl/jtcomsc_cmd_fifo.sv
// Byte FIFO of 2^AW entries for sound commands.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, pop       single-cycle requests; a pop on empty is ignored,
//                   a push on full is dropped unless a pop frees a slot
//                   in the same cycle
//   flush           clears pointers and count, wins over push/pop
//   din             byte written on an accepted push
//   head            entry at the read pointer
//   count           number of stored entries (0 .. 2^AW)
//   full, empty     count == 2^AW / count == 0
module jtcomsc_cmd_fifo
   import jtcomsc_snd_comm_pkg::*;
#(
   parameter int unsigned AW = 2
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [7:0]    din,
   output logic [7:0]    head,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   localparam int unsigned DEPTH = 1 << AW;

   cmd_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop;
   logic          do_push;

   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   // the pop frees its slot before the push is judged against full
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage; contents need no reset since count gates their use
   always_ff @(posedge clk) begin
      if (!flush && do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/jtcomsc_snd_comm.sv
// Sound-CPU side of the main-to-sound command channel.
// Each rising edge of snd_irq queues snd_latch; the sound CPU IRQ is held
// while commands are pending and irq_en is set. Reading the latch address
// returns the head byte and pops it once per access.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   snd_cen               sound CPU clock enable
//   snd_irq, snd_latch    command strobe and byte from the main CPU side
//   latch_cs, stat_cs     sound CPU selects for latch / status address
//   RnW, cpu_dout         sound CPU direction and write data
//   dout                  read data toward the sound CPU bus mux
//   snd_irqn              active-low IRQ to the sound CPU
module jtcomsc_snd_comm
   import jtcomsc_snd_comm_pkg::*;
#(
   parameter int unsigned AW = 2
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       snd_cen,
   input  logic       snd_irq,
   input  logic [7:0] snd_latch,
   input  logic       latch_cs,
   input  logic       stat_cs,
   input  logic       RnW,
   input  logic [7:0] cpu_dout,
   output logic [7:0] dout,
   output logic       snd_irqn
);

   localparam int unsigned OVF_BIT   = 7;
   localparam int unsigned IEN_BIT   = 6;
   localparam int unsigned FLUSH_BIT = 7;

   logic        irq_l;
   logic        rd_act;
   logic        ovf;
   logic        irq_en;
   cmd_t        last;
   logic [7:0]  head;
   logic [AW:0] count;
   logic        full;
   logic        empty;
   logic        push_c;
   logic        pop_c;
   logic        wr_c;
   logic        flush_c;

   assign push_c  = snd_irq && !irq_l;
   // only the first enabled cycle of a latch read pops
   assign pop_c   = latch_cs && RnW && snd_cen && !rd_act;
   assign wr_c    = stat_cs && !RnW && snd_cen;
   assign flush_c = wr_c && cpu_dout[FLUSH_BIT];

   jtcomsc_cmd_fifo #(.AW(AW)) u_fifo (
      .clk   ( clk       ),
      .rst   ( rst       ),
      .push  ( push_c    ),
      .pop   ( pop_c     ),
      .flush ( flush_c   ),
      .din   ( snd_latch ),
      .head  ( head      ),
      .count ( count     ),
      .full  ( full      ),
      .empty ( empty     )
   );

   // Edge detect, access tracking, status bits and IRQ
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_l    <= 1'b0;
         rd_act   <= 1'b0;
         ovf      <= 1'b0;
         irq_en   <= 1'b1;
         last     <= 8'h00;
         snd_irqn <= 1'b1;
      end else begin
         irq_l    <= snd_irq;
         rd_act   <= latch_cs && (rd_act || pop_c);
         snd_irqn <= !(irq_en && !empty);
         if (pop_c && !empty) last <= head;
         // a dropped push sets ovf only if no pop makes room
         if (flush_c)
            ovf <= 1'b0;
         else if (push_c && full && !(pop_c && !empty))
            ovf <= 1'b1;
         if (wr_c) irq_en <= cpu_dout[IEN_BIT];
      end
   end

   // Read data mux toward the sound CPU bus
   always_comb begin
      dout = 8'hff;
      if (latch_cs && RnW) begin
         dout = empty ? last : head;
      end else if (stat_cs && RnW) begin
         dout          = 8'(count);
         dout[OVF_BIT] = ovf;
         dout[IEN_BIT] = irq_en;
      end
   end

endmodule
